// File: rtl/pdh_ctrl_core.sv
// pdh_ctrl_core: PS GPIO command decoder driving LEDs and NUM_DAC DAC lanes,
// with ADC snapshot readback and a triangle-ramp generator on one DAC lane.
// Optional build macro: PDH_RAMP_TRIG_EN adds a one-clock ramp_trig_o pulse
// at each DOWN->UP turn-around; when undefined ramp_trig_o is tied low.
module pdh_ctrl_core #(
    parameter int NUM_DAC        = 2,
    parameter int NUM_ADC        = 2,
    parameter int DAC_DATA_WIDTH = 14,
    parameter int ADC_DATA_WIDTH = 16,
    parameter int RAMP_DIV_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_ADC*ADC_DATA_WIDTH-1:0] adc_tdata_i,
    input  logic                              adc_tvalid_i,
    output logic [NUM_DAC*16-1:0]             dac_tdata_o,
    output logic                              dac_tvalid_o,
    input  logic [31:0]                       axi_from_ps_i,
    output logic [31:0]                       axi_to_ps_o,
    output logic [7:0]                        led_o,
    output logic                              ramp_trig_o
);
    localparam int DW = DAC_DATA_WIDTH;

    localparam logic [3:0] CMD_IDLE      = 4'd0;
    localparam logic [3:0] CMD_SET_LED   = 4'd1;
    localparam logic [3:0] CMD_SET_DAC   = 4'd2;
    localparam logic [3:0] CMD_GET_ADC   = 4'd3;
    localparam logic [3:0] CMD_RAMP_LO   = 4'd4;
    localparam logic [3:0] CMD_RAMP_HI   = 4'd5;
    localparam logic [3:0] CMD_RAMP_STEP = 4'd6;
    localparam logic [3:0] CMD_RAMP_DIV  = 4'd7;
    localparam logic [3:0] CMD_RAMP_CTRL = 4'd8;

    typedef enum logic [1:0] {RAMP_IDLE, RAMP_UP, RAMP_DOWN} ramp_state_e;

    logic [31:0]                   gpio_q;
    logic                          strb_q;
    logic [NUM_DAC-1:0][DW-1:0]    code_q;
    logic [7:0]                    led_q;
    logic [DW-1:0]                 lo_q, hi_q, step_q;
    logic [RAMP_DIV_WIDTH-1:0]     div_q, div_cnt_q;
    logic [3:0]                    ramp_ch_q, adc_ch_q;
    ramp_state_e                   ramp_q;
    logic                          tvalid_q, pend_q, ack_q, err_q;
    logic [3:0]                    cmd_q;
    logic [23:0]                   payload_q;

    logic                          strb_edge, ramp_active, tick, cmd_err;
    logic [3:0]                    cmd, dac_ch, ctrl_ch, adc_sel;
    logic [25:0]                   data;
    logic [23:0]                   cmd_payload;
    logic [DW-1:0]                 ramp_val;
    logic [DW:0]                   sum_up, thr_down;
    logic [ADC_DATA_WIDTH-1:0]     adc_sample;
    logic                          unused_gpio;

    assign cmd         = gpio_q[29:26];
    assign data        = gpio_q[25:0];
    assign dac_ch      = data[25:22];
    assign ctrl_ch     = data[4:1];
    assign strb_edge   = gpio_q[30] & ~strb_q;
    assign ramp_active = (ramp_q != RAMP_IDLE);
    assign tick        = ramp_active && (div_cnt_q == div_q);
    assign sum_up      = {1'b0, ramp_val} + {1'b0, step_q};
    assign thr_down    = {1'b0, lo_q} + {1'b0, step_q};
    // Bit 31 and the data bits not used by any command are intentionally ignored.
    assign unused_gpio = ^gpio_q;
    // A GET_ADC strobe retargets capture to its own channel in the same cycle.
    assign adc_sel     = (strb_edge && cmd == CMD_GET_ADC) ? data[3:0] : adc_ch_q;

    // Lane muxes for the ramp lane and the selected ADC lane
    always_comb begin
        ramp_val   = '0;
        adc_sample = '0;
        for (int i = 0; i < NUM_DAC; i++)
            if (ramp_ch_q == 4'(i)) ramp_val = code_q[i];
        for (int i = 0; i < NUM_ADC; i++)
            if (adc_sel == 4'(i)) adc_sample = adc_tdata_i[i*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
    end

    // Command legality and callback payload for the strobed command
    always_comb begin
        cmd_err     = 1'b0;
        cmd_payload = '0;
        case (cmd)
            CMD_IDLE: ;
            CMD_SET_LED: cmd_payload = {16'd0, data[7:0]};
            CMD_SET_DAC: begin
                if (32'(dac_ch) >= NUM_DAC || (ramp_active && dac_ch == ramp_ch_q))
                    cmd_err = 1'b1;
                else
                    cmd_payload = {dac_ch, 6'd0, data[13:0]};
            end
            CMD_GET_ADC: cmd_err = (32'(data[3:0]) >= NUM_ADC);
            CMD_RAMP_LO, CMD_RAMP_HI, CMD_RAMP_STEP: begin
                if (ramp_active) cmd_err = 1'b1;
                else             cmd_payload = {10'd0, data[13:0]};
            end
            CMD_RAMP_DIV: cmd_payload = 24'(data[RAMP_DIV_WIDTH-1:0]);
            CMD_RAMP_CTRL: begin
                // Disabling is always legal; enabling needs a sane window.
                if (data[0] && (32'(ctrl_ch) >= NUM_DAC || lo_q >= hi_q || step_q == '0))
                    cmd_err = 1'b1;
                else
                    cmd_payload = {19'd0, data[4:0]};
            end
            default: cmd_err = 1'b1;
        endcase
    end

    // Main state: GPIO capture, ramp FSM, ADC capture, then command effects (last wins)
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_q    <= '0;
            strb_q    <= 1'b0;
            code_q    <= '0;
            led_q     <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            step_q    <= '0;
            div_q     <= '0;
            div_cnt_q <= '0;
            ramp_ch_q <= '0;
            adc_ch_q  <= '0;
            ramp_q    <= RAMP_IDLE;
            tvalid_q  <= 1'b0;
            pend_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            cmd_q     <= '0;
            payload_q <= '0;
        end else begin
            gpio_q   <= axi_from_ps_i;
            strb_q   <= gpio_q[30];
            tvalid_q <= 1'b0;

            if (ramp_active) begin
                div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
                if (tick) begin
                    tvalid_q <= 1'b1;
                    for (int i = 0; i < NUM_DAC; i++) begin
                        if (ramp_ch_q == 4'(i)) begin
                            if (ramp_q == RAMP_UP) begin
                                if (sum_up >= {1'b0, hi_q}) code_q[i] <= hi_q;
                                else                        code_q[i] <= sum_up[DW-1:0];
                            end else begin
                                if ({1'b0, ramp_val} <= thr_down) code_q[i] <= lo_q;
                                else                              code_q[i] <= ramp_val - step_q;
                            end
                        end
                    end
                    if (ramp_q == RAMP_UP && sum_up >= {1'b0, hi_q})
                        ramp_q <= RAMP_DOWN;
                    else if (ramp_q == RAMP_DOWN && {1'b0, ramp_val} <= thr_down)
                        ramp_q <= RAMP_UP;
                end
            end

            if (pend_q && adc_tvalid_i) begin
                pend_q    <= 1'b0;
                payload_q <= 24'(adc_sample);
            end

            if (strb_edge) begin
                ack_q     <= ~ack_q;
                cmd_q     <= cmd;
                err_q     <= cmd_err;
                payload_q <= cmd_payload;
                if (!cmd_err) begin
                    case (cmd)
                        CMD_SET_LED: led_q <= data[7:0];
                        CMD_SET_DAC: begin
                            tvalid_q <= 1'b1;
                            for (int i = 0; i < NUM_DAC; i++)
                                if (dac_ch == 4'(i)) code_q[i] <= data[DW-1:0];
                        end
                        CMD_GET_ADC: begin
                            adc_ch_q <= data[3:0];
                            if (adc_tvalid_i) begin
                                pend_q    <= 1'b0;
                                payload_q <= 24'(adc_sample);
                            end else begin
                                pend_q    <= 1'b1;
                            end
                        end
                        CMD_RAMP_LO:   lo_q   <= data[DW-1:0];
                        CMD_RAMP_HI:   hi_q   <= data[DW-1:0];
                        CMD_RAMP_STEP: step_q <= data[DW-1:0];
                        CMD_RAMP_DIV:  div_q  <= data[RAMP_DIV_WIDTH-1:0];
                        CMD_RAMP_CTRL: begin
                            if (data[0]) begin
                                ramp_ch_q <= ctrl_ch;
                                div_cnt_q <= '0;
                                ramp_q    <= RAMP_UP;
                                tvalid_q  <= 1'b1;
                                for (int i = 0; i < NUM_DAC; i++)
                                    if (ctrl_ch == 4'(i)) code_q[i] <= lo_q;
                            end else begin
                                ramp_q <= RAMP_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef PDH_RAMP_TRIG_EN
    logic trig_q;
    // Scope sync: flag the tick where the falling edge lands on lo
    always_ff @(posedge clk) begin
        if (rst) trig_q <= 1'b0;
        else     trig_q <= tick && (ramp_q == RAMP_DOWN) && ({1'b0, ramp_val} <= thr_down);
    end
    assign ramp_trig_o = trig_q;
`else
    assign ramp_trig_o = 1'b0;
`endif

    for (genvar g = 0; g < NUM_DAC; g++) begin : g_lane
        assign dac_tdata_o[g*16 +: 16] = 16'(code_q[g]);
    end

    assign dac_tvalid_o = tvalid_q;
    assign led_o        = led_q;
    assign axi_to_ps_o  = {cmd_q, err_q, ramp_active, ack_q, pend_q, payload_q};

endmodule

// File: tb/tb_pdh_ctrl_core.sv
// Directed bench for pdh_ctrl_core (default parameters).
module tb_pdh_ctrl_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adc_tdata;
    logic        adc_tvalid;
    logic [31:0] dac_tdata;
    logic        dac_tvalid;
    logic [31:0] from_ps;
    logic [31:0] to_ps;
    logic [7:0]  led;
    logic        trig;

    int checks = 0;
    int errors = 0;

    pdh_ctrl_core dut (
        .clk(clk), .rst(rst),
        .adc_tdata_i(adc_tdata), .adc_tvalid_i(adc_tvalid),
        .dac_tdata_o(dac_tdata), .dac_tvalid_o(dac_tvalid),
        .axi_from_ps_i(from_ps), .axi_to_ps_o(to_ps),
        .led_o(led), .ramp_trig_o(trig)
    );

    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    // Strobe a command; returns on the negedge where its effects are first visible.
    task automatic strobe(input logic [3:0] cmd, input logic [25:0] data);
        @(negedge clk);
        from_ps = {1'b0, 1'b1, cmd, data};
        @(negedge clk);
        @(negedge clk);
        from_ps = '0;
    endtask

    logic [13:0] seq1 [8] = '{14'd100, 14'd110, 14'd120, 14'd130, 14'd120, 14'd110, 14'd100, 14'd110};
    logic [13:0] seq2 [8] = '{14'd0, 14'd7, 14'd14, 14'd20, 14'd13, 14'd6, 14'd0, 14'd7};
    logic        exp_trig;

    initial begin
        rst = 1'b1; from_ps = '0; adc_tdata = {16'hBEEF, 16'h1111}; adc_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_led", {24'd0, led}, 32'h0);
        chk("rst_cb", to_ps, 32'h0);
        chk("rst_dac", dac_tdata, 32'h0);
        chk("rst_tvalid", {31'd0, dac_tvalid}, 32'h0);
        chk("rst_trig", {31'd0, trig}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // LED
        strobe(4'd1, 26'h0A5);
        chk("led", {24'd0, led}, 32'hA5);
        chk("led_cb", to_ps, 32'h120000A5);

        // SET_DAC ch1 and an out-of-range channel
        strobe(4'd2, 26'h0401234);
        chk("dac1_data", dac_tdata, 32'h12340000);
        chk("dac1_tvalid", {31'd0, dac_tvalid}, 32'h1);
        chk("dac1_cb", to_ps, 32'h20101234);
        @(negedge clk);
        chk("dac1_tvalid_drop", {31'd0, dac_tvalid}, 32'h0);
        strobe(4'd2, 26'h1400777);
        chk("dac5_cb", to_ps, 32'h2A000000);
        chk("dac5_data", dac_tdata, 32'h12340000);
        chk("dac5_tvalid", {31'd0, dac_tvalid}, 32'h0);

        // Ramp 100..130 step 10, div 0, lane 0
        strobe(4'd4, 26'd100);
        chk("lo_cb", to_ps, 32'h40000064);
        strobe(4'd5, 26'd130);
        strobe(4'd6, 26'd10);
        strobe(4'd7, 26'd0);
        chk("div_cb", to_ps, 32'h72000000);
        strobe(4'd8, 26'h1);
        chk("en_cb", to_ps, 32'h84000001);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("ramp1_%0d", k), {16'd0, dac_tdata[15:0]}, {18'd0, seq1[k]});
            chk($sformatf("ramp1_tv_%0d", k), {31'd0, dac_tvalid}, 32'h1);
`ifdef PDH_RAMP_TRIG_EN
            exp_trig = (k == 6);
`else
            exp_trig = 1'b0;
`endif
            chk($sformatf("ramp1_trig_%0d", k), {31'd0, trig}, {31'd0, exp_trig});
        end
        strobe(4'd8, 26'h0);
        chk("dis1_cb", to_ps, 32'h82000000);

        // Ramp 0..20 step 7: clamps at both ends
        strobe(4'd4, 26'd0);
        strobe(4'd5, 26'd20);
        strobe(4'd6, 26'd7);
        strobe(4'd8, 26'h1);
        chk("en2_cb", to_ps, 32'h86000001);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("ramp2_%0d", k), {16'd0, dac_tdata[15:0]}, {18'd0, seq2[k]});
        end
        // SET_DAC to the ramp lane mid-ramp is rejected; ramp keeps going
        strobe(4'd2, 26'h0000777);
        chk("dac0_busy_cb", to_ps, 32'h2C000000);
        chk("dac0_busy_lane", {16'd0, dac_tdata[15:0]}, 32'd13);
        // Disable: one final tick lands with the disable, then the lane holds
        strobe(4'd8, 26'h0);
        chk("dis2_cb", to_ps, 32'h82000000);
        chk("dis2_lane", {16'd0, dac_tdata[15:0]}, 32'd7);
        repeat (3) @(negedge clk);
        chk("dis2_hold", {16'd0, dac_tdata[15:0]}, 32'd7);
        chk("dis2_tvalid", {31'd0, dac_tvalid}, 32'h0);

        // GET_ADC with a delayed valid
        strobe(4'd3, 26'h1);
        chk("adc_pend", to_ps, 32'h31000000);
        repeat (5) @(negedge clk);
        chk("adc_pend_hold", to_ps, 32'h31000000);
        adc_tvalid = 1'b1;
        @(negedge clk);
        adc_tvalid = 1'b0;
        chk("adc_capture", to_ps, 32'h3000BEEF);

        // Reset mid-ramp, then an empty window enable
        strobe(4'd8, 26'h1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst2_cb", to_ps, 32'h0);
        chk("rst2_dac", dac_tdata, 32'h0);
        chk("rst2_led", {24'd0, led}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        strobe(4'd4, 26'd50);
        strobe(4'd5, 26'd50);
        strobe(4'd6, 26'd1);
        strobe(4'd8, 26'h1);
        chk("empty_en_cb", to_ps, 32'h88000000);
        chk("empty_en_tvalid", {31'd0, dac_tvalid}, 32'h0);
        repeat (2) @(negedge clk);
        chk("empty_en_lane", dac_tdata, 32'h0);
        chk("empty_en_idle", {31'd0, to_ps[26]}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
